raw_data_packer: RTL and testbench

RAW_DATA_PACKER -- requirements
Module: raw_data_packer

---
 rtl/raw_data_packer_pkg.sv | 18 +
 rtl/raw_data_packer.sv | 173 +++++++++++++++++
 tb/tb_raw_data_packer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raw_data_packer_pkg.sv
// -----------------------------------------------------------------------------
// raw_data_packer_pkg
// Shared definitions for the raw data packer: FSM state encoding and the
// default values of the packer parameters.
// -----------------------------------------------------------------------------
package raw_data_packer_pkg;

   // COLLECT gathers raw words into lanes, HOLD presents a finished beat.
   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_W = 32'd32;
   localparam int unsigned DEF_PACK_N = 32'd4;
   localparam int unsigned DEF_TMO_W  = 32'd8;

endpackage : raw_data_packer_pkg

// File: rtl/raw_data_packer.sv
// -----------------------------------------------------------------------------
// raw_data_packer
// Packs PACK_N consecutive raw words into one wide beat. A beat is emitted
// when full, on flush (if at least one word is buffered or arriving), or --
// when built with PACKER_TIMEOUT_EN -- after 2^TMO_W-1 idle cycles with a
// partial beat buffered. The beat is held stable until the consumer takes it.
//
// Optional feature macro: PACKER_TIMEOUT_EN (idle-timeout internal flush).
//
// Ports
//   clk                in   clock, all logic on rising edge
//   reset_n            in   synchronous active-low reset
//   raw_data_in        in   DATA_W   upstream word
//   raw_data_valid     in   upstream word present
//   raw_data_accepted  out  word consumed this cycle (combinational)
//   flush              in   emit the partial beat now
//   packed_data        out  PACK_N*DATA_W packed beat, word 0 in the LSBs
//   packed_count       out  number of valid words in packed_data
//   packed_valid       out  beat present
//   packed_ready       in   downstream takes the beat on valid & ready
// -----------------------------------------------------------------------------
module raw_data_packer
   import raw_data_packer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned PACK_N = DEF_PACK_N,
   parameter int unsigned TMO_W  = DEF_TMO_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_W-1:0]             raw_data_in,
   input  logic                          raw_data_valid,
   output logic                          raw_data_accepted,
   input  logic                          flush,
   output logic [PACK_N*DATA_W-1:0]      packed_data,
   output logic [$clog2(PACK_N+1)-1:0]   packed_count,
   output logic                          packed_valid,
   input  logic                          packed_ready
);

   localparam int unsigned CNT_W = $clog2(PACK_N + 1);

   // Parameter sanity: a beat needs at least two lanes, the timer one bit.
   if ((PACK_N < 2) || (TMO_W < 1)) begin : g_bad_param
      $error("raw_data_packer: PACK_N must be >= 2 and TMO_W >= 1");
   end

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
   logic [PACK_N*DATA_W-1:0]   lanes_q, lanes_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       accept_s;
   logic [CNT_W-1:0]           cnt_after_s;
   logic                       tmo_fire_s;

`ifdef PACKER_TIMEOUT_EN
   // Fire one cycle early so the counter "reaches" its maximum on the very
   // edge that moves the FSM into HOLD.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);

   logic [TMO_W-1:0]           tmo_q, tmo_d;

   assign tmo_fire_s = (state_q == COLLECT) && (word_cnt_q != '0) &&
                       !accept_s && (tmo_q == TMO_LAST);
`else
   assign tmo_fire_s = 1'b0;
`endif

   // Gated by reset_n so nothing is consumed while the block is held in reset.
   assign accept_s          = reset_n && (state_q == COLLECT) && raw_data_valid;
   assign raw_data_accepted = accept_s;

   assign packed_valid = (state_q == HOLD);
   assign packed_data  = lanes_q;
   assign packed_count = count_q;

   // Next-state, lane write and beat-close decisions.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      lanes_d     = lanes_q;
      count_d     = count_q;
      cnt_after_s = word_cnt_q + CNT_W'(accept_s);
`ifdef PACKER_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         COLLECT: begin
            if (accept_s) begin
               for (int i = 0; i < PACK_N; i++) begin
                  if (word_cnt_q == CNT_W'(i)) begin
                     lanes_d[i*DATA_W +: DATA_W] = raw_data_in;
                  end else begin
                     lanes_d[i*DATA_W +: DATA_W] = lanes_q[i*DATA_W +: DATA_W];
                  end
               end
`ifdef PACKER_TIMEOUT_EN
               tmo_d = '0;
`endif
            end else begin
`ifdef PACKER_TIMEOUT_EN
               // Only a partially filled beat ages.
               if (word_cnt_q != '0) begin
                  tmo_d = tmo_q + TMO_W'(1);
               end else begin
                  tmo_d = '0;
               end
`endif
               lanes_d = lanes_q;
            end

            word_cnt_d = cnt_after_s;

            // Count includes a word accepted in this same cycle.
            if ((cnt_after_s == CNT_W'(PACK_N)) ||
                ((flush || tmo_fire_s) && (cnt_after_s != '0))) begin
               state_d = HOLD;
               count_d = cnt_after_s;
`ifdef PACKER_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end else begin
               state_d = COLLECT;
            end
         end

         HOLD: begin
            // flush is deliberately ignored here; the beat waits for ready.
            if (packed_ready) begin
               state_d    = COLLECT;
               lanes_d    = '0;
               word_cnt_d = '0;
               count_d    = '0;
            end else begin
               state_d = HOLD;
            end
         end

         default: begin
            state_d    = COLLECT;
            lanes_d    = '0;
            word_cnt_d = '0;
            count_d    = '0;
`ifdef PACKER_TIMEOUT_EN
            tmo_d      = '0;
`endif
         end
      endcase
   end

   // State register with synchronous active-low reset discarding any beat.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= COLLECT;
         word_cnt_q <= '0;
         lanes_q    <= '0;
         count_q    <= '0;
`ifdef PACKER_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         lanes_q    <= lanes_d;
         count_q    <= count_d;
`ifdef PACKER_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

endmodule : raw_data_packer

// File: tb/tb_raw_data_packer.sv
module tb_raw_data_packer;

   localparam int DATA_W = 32;
   localparam int PACK_N = 4;
   localparam int TMO_W  = 4;
   localparam int BEAT_W = DATA_W * PACK_N;
   localparam int CNT_W  = $clog2(PACK_N + 1);

   typedef struct {
      logic [BEAT_W-1:0] data;
      logic [CNT_W-1:0]  count;
   } beat_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [DATA_W-1:0]  raw_data_in = '0;
   logic               raw_data_valid = 1'b0;
   logic               raw_data_accepted;
   logic               flush = 1'b0;
   logic [BEAT_W-1:0]  packed_data;
   logic [CNT_W-1:0]   packed_count;
   logic               packed_valid;
   logic               packed_ready = 1'b0;

   int    checks   = 0;
   int    failures = 0;
   logic  acc_seen;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   raw_data_packer #(
      .DATA_W(DATA_W),
      .PACK_N(PACK_N),
      .TMO_W (TMO_W)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .raw_data_in      (raw_data_in),
      .raw_data_valid   (raw_data_valid),
      .raw_data_accepted(raw_data_accepted),
      .flush            (flush),
      .packed_data      (packed_data),
      .packed_count     (packed_count),
      .packed_valid     (packed_valid),
      .packed_ready     (packed_ready)
   );

   task automatic chk(input string tag, input logic [BEAT_W-1:0] obs,
                      input logic [BEAT_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [BEAT_W-1:0] d, input logic [CNT_W-1:0] c);
      beat_t b;
      b.data  = d;
      b.count = c;
      exp_q.push_back(b);
   endtask

   // Sample just before the next edge (handshake check), then advance one cycle.
   task automatic tick();
      beat_t e;
      #1;
      acc_seen = raw_data_accepted;
      if (packed_valid === 1'b1 && packed_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", packed_data, '0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", packed_data, e.data);
            chk("beat_count", BEAT_W'(packed_count), BEAT_W'(e.count));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      logic got;
      got = 1'b0;
      raw_data_in    = w;
      raw_data_valid = 1'b1;
      for (int k = 0; k < 32 && !got; k++) begin
         tick();
         got = acc_seen;
      end
      raw_data_valid = 1'b0;
      raw_data_in    = '0;
      if (!got) chk("accept_timeout", BEAT_W'(got), BEAT_W'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: valid upstream word must not be consumed while in reset.
      reset_n        = 1'b0;
      raw_data_valid = 1'b1;
      raw_data_in    = 32'hDEAD_BEEF;
      tick();
      tick();
      chk("rst_valid", BEAT_W'(packed_valid), BEAT_W'(0));
      chk("rst_count", BEAT_W'(packed_count), BEAT_W'(0));
      chk("rst_data", packed_data, '0);
      #1;
      chk("rst_accepted", BEAT_W'(raw_data_accepted), BEAT_W'(0));
      raw_data_valid = 1'b0;
      reset_n        = 1'b1;
      tick();

      // Full beat, ready high, valid one cycle after the 4th accept.
      packed_ready = 1'b1;
      push({32'h44, 32'h33, 32'h22, 32'h11}, 3'd4);
      send_word(32'h11);
      send_word(32'h22);
      send_word(32'h33);
      chk("full_before_last", BEAT_W'(packed_valid), BEAT_W'(0));
      send_word(32'h44);
      chk("latency_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();

      // Partial beat via flush, unused lanes zero.
      push({32'h0, 32'h0, 32'hB, 32'hA}, 3'd2);
      send_word(32'hA);
      send_word(32'hB);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();

      // Flush with nothing buffered is ignored.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("empty_flush_valid", BEAT_W'(packed_valid), BEAT_W'(0));
      tick();
      chk("empty_flush_valid2", BEAT_W'(packed_valid), BEAT_W'(0));

      // Backpressure: beat held, no accepts, flush ignored in HOLD.
      packed_ready = 1'b0;
      push({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 3'd4);
      send_word(32'hD1);
      send_word(32'hD2);
      send_word(32'hD3);
      send_word(32'hD4);
      raw_data_valid = 1'b1;
      raw_data_in    = 32'hEE;
      flush          = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_accepted", BEAT_W'(acc_seen), BEAT_W'(0));
         chk("hold_valid", BEAT_W'(packed_valid), BEAT_W'(1));
         chk("hold_data", packed_data, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
         chk("hold_count", BEAT_W'(packed_count), BEAT_W'(4));
      end
      flush          = 1'b0;
      packed_ready   = 1'b1;
      tick();
      // Handshake cycle: still HOLD, word must not be taken yet.
      chk("handshake_no_accept", BEAT_W'(acc_seen), BEAT_W'(0));
      raw_data_valid = 1'b0;
      tick();

      // Flush coincident with the 3rd accept counts that word.
      push({32'h0, 32'h53, 32'h52, 32'h51}, 3'd3);
      send_word(32'h51);
      send_word(32'h52);
      flush = 1'b1;
      send_word(32'h53);
      flush = 1'b0;
      chk("flush3_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();

      // Reset while holding a beat discards it.
      packed_ready = 1'b0;
      send_word(32'h61);
      send_word(32'h62);
      send_word(32'h63);
      send_word(32'h64);
      chk("pre_reset_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("post_reset_valid", BEAT_W'(packed_valid), BEAT_W'(0));
      chk("post_reset_count", BEAT_W'(packed_count), BEAT_W'(0));
      chk("post_reset_data", packed_data, '0);
      packed_ready = 1'b1;
      push({32'h74, 32'h73, 32'h72, 32'h71}, 3'd4);
      send_word(32'h71);
      send_word(32'h72);
      send_word(32'h73);
      send_word(32'h74);
      tick();
      tick();

`ifdef PACKER_TIMEOUT_EN
      // One word then idle: beat after 15 idle cycles.
      push({32'h0, 32'h0, 32'h0, 32'h81}, 3'd1);
      send_word(32'h81);
      for (int c = 0; c < 14; c++) begin
         tick();
         chk("tmo_wait_valid", BEAT_W'(packed_valid), BEAT_W'(0));
      end
      tick();
      chk("tmo_fire_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();

      // Accept after 10 idle cycles restarts the count.
      push({32'h0, 32'h0, 32'h92, 32'h91}, 3'd2);
      send_word(32'h91);
      for (int c = 0; c < 9; c++) tick();
      send_word(32'h92);
      for (int c = 0; c < 14; c++) begin
         tick();
         chk("tmo_restart_wait", BEAT_W'(packed_valid), BEAT_W'(0));
      end
      tick();
      chk("tmo_restart_fire", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();
`else
      // Without the timeout a partial beat waits for flush indefinitely.
      push({32'h0, 32'h0, 32'h0, 32'h81}, 3'd1);
      send_word(32'h81);
      for (int c = 0; c < 20; c++) tick();
      chk("no_tmo_valid", BEAT_W'(packed_valid), BEAT_W'(0));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("no_tmo_flush_valid", BEAT_W'(packed_valid), BEAT_W'(1));
      tick();
      tick();
`endif

      chk("queue_drained", BEAT_W'(exp_q.size()), BEAT_W'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_raw_data_packer
